// File: rtl/phase_error_tdc_if.sv
// Result handshake between the phase-error TDC and the loop filter.
// The TDC drives a signed error with flags, and the consumer returns err_ready.
interface phase_error_tdc_if #(
    parameter int CNT_W = 12
);
    logic signed [CNT_W:0] phase_err;
    logic                  lead;
    logic                  timeout;
    logic                  err_valid;
    logic                  err_ready;

    modport master (
        output phase_err, lead, timeout, err_valid,
        input  err_ready
    );

    modport slave (
        input  phase_err, lead, timeout, err_valid,
        output err_ready
    );
endinterface

// File: rtl/phase_error_tdc.sv
// Signed, cycle-resolution TDC for the ADPLL phase-error path: it measures the clk cycles
// between ref and feedback rising edges and reports lead/lag and timeout over a valid/ready handshake.
module phase_error_tdc #(
    parameter int CNT_W       = 12,
    parameter int TIMEOUT     = 4095,
    parameter int SYNC_STAGES = 2,
    parameter int DROP_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              ref_signal,
    input  logic              feedback_signal,
    phase_error_tdc_if.master err_if,
    output logic              busy,
    output logic [DROP_W-1:0] drop_count
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REF_FIRST, FB_FIRST, HOLD} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [SYNC_STAGES-1:0] ref_sync;
    logic [SYNC_STAGES-1:0] fb_sync;
    logic                   ref_dly;
    logic                   fb_dly;
    logic                   ref_edge;
    logic                   fb_edge;

    // Both inputs see the same pipeline depth, so their relative timing is preserved.
    always_ff @(posedge clk) begin
        if (reset) begin
            ref_sync <= '0;
            fb_sync  <= '0;
            ref_dly  <= 1'b0;
            fb_dly   <= 1'b0;
        end else begin
            ref_sync[0] <= ref_signal;
            fb_sync[0]  <= feedback_signal;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                ref_sync[i] <= ref_sync[i-1];
                fb_sync[i]  <= fb_sync[i-1];
            end
            ref_dly <= ref_sync[SYNC_STAGES-1];
            fb_dly  <= fb_sync[SYNC_STAGES-1];
        end
    end

    assign ref_edge = ref_sync[SYNC_STAGES-1] & ~ref_dly;
    assign fb_edge  = fb_sync[SYNC_STAGES-1] & ~fb_dly;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            cnt              <= '0;
            err_if.phase_err <= '0;
            err_if.lead      <= 1'b0;
            err_if.timeout   <= 1'b0;
            err_if.err_valid <= 1'b0;
            busy             <= 1'b0;
            drop_count       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        if (ref_edge && fb_edge) begin
                            err_if.phase_err <= '0;
                            err_if.lead      <= 1'b0;
                            err_if.timeout   <= 1'b0;
                            err_if.err_valid <= 1'b1;
                            state            <= HOLD;
                        end else if (ref_edge) begin
                            cnt   <= CNT_W'(1);
                            busy  <= 1'b1;
                            state <= REF_FIRST;
                        end else if (fb_edge) begin
                            cnt   <= CNT_W'(1);
                            busy  <= 1'b1;
                            state <= FB_FIRST;
                        end
                    end
                end

                // Closing edge is checked before the timeout, so an edge landing on the
                // last counted cycle still reports a real measurement.
                REF_FIRST: begin
                    if (!enable) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (fb_edge || cnt == TIMEOUT_CNT) begin
                        err_if.phase_err <= $signed({1'b0, cnt});
                        err_if.lead      <= 1'b1;
                        err_if.timeout   <= ~fb_edge;
                        err_if.err_valid <= 1'b1;
                        busy             <= 1'b0;
                        state            <= HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                FB_FIRST: begin
                    if (!enable) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (ref_edge || cnt == TIMEOUT_CNT) begin
                        err_if.phase_err <= -$signed({1'b0, cnt});
                        err_if.lead      <= 1'b0;
                        err_if.timeout   <= ~ref_edge;
                        err_if.err_valid <= 1'b1;
                        busy             <= 1'b0;
                        state            <= HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Reference edges that arrive while a result is waiting are counted as lost.
                HOLD: begin
                    if (ref_edge && drop_count != '1) begin
                        drop_count <= drop_count + 1'b1;
                    end
                    if (err_if.err_ready) begin
                        err_if.err_valid <= 1'b0;
                        state            <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
